// File: rtl/product_bcd_conv.sv
// rtl/product_bcd_conv.sv - sequential double-dabble binary to packed BCD converter
// One shift per clock; the result is held with bcd_valid until the next accepted start edge.
module product_bcd_conv #(
    parameter int BIN_W  = 16,
    parameter int DIGITS = 5
) (
    input  logic                  clk,
    input  logic                  aclr_n,
    input  logic                  start,
    input  logic [BIN_W-1:0]      bin_in,
    output logic                  busy,
    output logic                  bcd_valid,
    output logic [4*DIGITS-1:0]   bcd_out
);

    localparam int CNT_W = $clog2(BIN_W + 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t                r_state;
    state_t                w_next;
    logic                  r_start_q;
    logic                  r_armed;
    logic [BIN_W-1:0]      r_bin;
    logic [4*DIGITS-1:0]   r_scratch;
    logic [4*DIGITS-1:0]   r_bcd;
    logic [4*DIGITS-1:0]   w_adj;
    logic [CNT_W-1:0]      r_cnt;
    logic                  r_busy;
    logic                  r_valid;
    logic                  w_accept;
    logic                  w_last;

    // r_armed masks the first cycle after reset so a start held high through release is not an edge.
    assign w_accept = start & ~r_start_q & r_armed &
                      ((r_state == S_IDLE) || (r_state == S_DONE));
    assign w_last   = (r_cnt == CNT_W'(BIN_W));

    always_comb begin
        w_adj = r_scratch;
        for (int d = 0; d < DIGITS; d++) begin
            if (r_scratch[4*d +: 4] >= 4'd5)
                w_adj[4*d +: 4] = r_scratch[4*d +: 4] + 4'd3;
        end
    end

    always_ff @(posedge clk or negedge aclr_n) begin
        if (!aclr_n)
            r_state <= S_IDLE;
        else
            r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE,
            S_DONE:  if (w_accept) w_next = S_SHIFT;
            S_SHIFT: if (w_last)   w_next = S_DONE;
            default: w_next = S_IDLE;
        endcase
    end

    // The transfer cycle after the 16th shift keeps busy high through N+16 and spaces conversions 18 clocks apart.
    always_ff @(posedge clk or negedge aclr_n) begin
        if (!aclr_n) begin
            r_start_q <= 1'b0;
            r_armed   <= 1'b0;
            r_bin     <= '0;
            r_scratch <= '0;
            r_bcd     <= '0;
            r_cnt     <= '0;
            r_busy    <= 1'b0;
            r_valid   <= 1'b0;
        end else begin
            r_start_q <= start;
            r_armed   <= 1'b1;
            if (w_accept) begin
                r_bin     <= bin_in;
                r_scratch <= '0;
                r_cnt     <= '0;
                r_busy    <= 1'b1;
                r_valid   <= 1'b0;
            end else if (r_state == S_SHIFT) begin
                if (w_last) begin
                    r_bcd   <= r_scratch;
                    r_valid <= 1'b1;
                    r_busy  <= 1'b0;
                end else begin
                    r_scratch <= {w_adj[4*DIGITS-2:0], r_bin[BIN_W-1]};
                    r_bin     <= {r_bin[BIN_W-2:0], 1'b0};
                    r_cnt     <= r_cnt + CNT_W'(1);
                end
            end
        end
    end

    assign busy      = r_busy;
    assign bcd_valid = r_valid;
    assign bcd_out   = r_bcd;

endmodule

// File: tb/tb_product_bcd_conv.sv
// tb/tb_product_bcd_conv.sv - scoreboard bench for product_bcd_conv
module tb_product_bcd_conv;

    logic        clk = 1'b0;
    logic        aclr_n;
    logic        start;
    logic [15:0] bin_in;
    logic        busy;
    logic        bcd_valid;
    logic [19:0] bcd_out;

    int          n_cmp  = 0;
    int          n_err  = 0;
    int          n_done = 0;
    logic [19:0] exp_q[$];
    logic        prev_valid = 1'b0;
    logic [19:0] mon_exp;

    product_bcd_conv #(.BIN_W(16), .DIGITS(5)) dut (
        .clk       (clk),
        .aclr_n    (aclr_n),
        .start     (start),
        .bin_in    (bin_in),
        .busy      (busy),
        .bcd_valid (bcd_valid),
        .bcd_out   (bcd_out)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (aclr_n && bcd_valid && !prev_valid) begin
            n_done++;
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL unexpected_result: got %05h expected none", bcd_out);
            end else begin
                mon_exp = exp_q.pop_front();
                check("scoreboard_bcd_out", {12'd0, bcd_out}, {12'd0, mon_exp});
            end
        end
        prev_valid = bcd_valid;
    end

    task automatic do_conv(input logic [15:0] v, input logic [19:0] e, input string tag);
        int  busy_cnt;
        int  lat;
        bit  got;
        busy_cnt = 0;
        lat      = 0;
        got      = 0;
        @(negedge clk);
        bin_in = v;
        start  = 1'b1;
        exp_q.push_back(e);
        for (int i = 1; i <= 40 && !got; i++) begin
            @(negedge clk);
            if (i == 1) check({tag, "_valid_cleared"}, {31'd0, bcd_valid}, 32'd0);
            if (busy) busy_cnt++;
            if (bcd_valid) begin
                got = 1;
                lat = i;
            end
        end
        if (!got) begin
            n_cmp++;
            n_err++;
            $display("FAIL %s_timeout: got no bcd_valid expected within 40 cycles", tag);
        end
        check({tag, "_latency"}, lat, 32'd18);
        check({tag, "_busy_cycles"}, busy_cnt, 32'd17);
        start = 1'b0;
        #2;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int d0;
        bit got;
        aclr_n = 1'b0;
        start  = 1'b1;
        bin_in = 16'd77;
        repeat (3) @(negedge clk);
        check("reset_busy", {31'd0, busy}, 32'd0);
        check("reset_valid", {31'd0, bcd_valid}, 32'd0);
        check("reset_bcd_out", {12'd0, bcd_out}, 32'd0);

        // start already high at release must not trigger a conversion
        aclr_n = 1'b1;
        repeat (20) @(negedge clk);
        check("held_start_busy", {31'd0, busy}, 32'd0);
        check("held_start_valid", {31'd0, bcd_valid}, 32'd0);
        start = 1'b0;
        repeat (2) @(negedge clk);

        do_conv(16'd0, 20'h00000, "t1_zero");
        check("t1_direct", {12'd0, bcd_out}, 32'h00000);
        do_conv(16'd65025, 20'h65025, "t2_65025");

        do_conv(16'd225, 20'h00225, "t3a_225");
        repeat (3) @(negedge clk);
        @(negedge clk);
        bin_in = 16'd65535;
        start  = 1'b1;
        exp_q.push_back(20'h65535);
        @(negedge clk);
        check("t3_valid_low_between", {31'd0, bcd_valid}, 32'd0);
        check("t3_old_value_held", {12'd0, bcd_out}, 32'h00225);
        bin_in = 16'd3;
        got = 0;
        for (int i = 0; i < 40 && !got; i++) begin
            @(negedge clk);
            if (bcd_valid) got = 1;
        end
        check("t3b_done", {31'd0, got}, 32'd1);
        check("t3b_direct", {12'd0, bcd_out}, 32'h65535);
        start = 1'b0;
        repeat (3) @(negedge clk);

        @(negedge clk);
        d0 = n_done;
        bin_in = 16'd1000;
        start  = 1'b1;
        exp_q.push_back(20'h01000);
        repeat (40) @(negedge clk);
        start = 1'b0;
        repeat (25) @(negedge clk);
        #2;
        check("t4_one_conversion", n_done - d0, 32'd1);
        check("t4_queue_empty", exp_q.size(), 32'd0);
        check("t4_direct", {12'd0, bcd_out}, 32'h01000);

        @(negedge clk);
        d0 = n_done;
        bin_in = 16'd4321;
        start  = 1'b1;
        exp_q.push_back(20'h04321);
        repeat (2) @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        bin_in = 16'd9;
        start  = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (40) @(negedge clk);
        #2;
        check("t5_one_conversion", n_done - d0, 32'd1);
        check("t5_direct", {12'd0, bcd_out}, 32'h04321);
        check("t5_idle_busy", {31'd0, busy}, 32'd0);

        @(negedge clk);
        bin_in = 16'd12345;
        start  = 1'b1;
        exp_q.push_back(20'h12345);
        repeat (8) @(negedge clk);
        #2;
        aclr_n = 1'b0;
        #1;
        check("t6_abort_busy", {31'd0, busy}, 32'd0);
        check("t6_abort_valid", {31'd0, bcd_valid}, 32'd0);
        check("t6_abort_bcd_out", {12'd0, bcd_out}, 32'd0);
        exp_q.delete();
        @(negedge clk);
        start  = 1'b0;
        aclr_n = 1'b1;
        repeat (3) @(negedge clk);
        do_conv(16'd12345, 20'h12345, "t6_rerun");
        do_conv(16'd65535, 20'h65535, "t7_max");

        repeat (5) @(negedge clk);
        check("final_queue_empty", exp_q.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
